uart_rx_fifo: RTL and testbench

Receive-side byte buffer directly downstream of the UART receiver. It captures each byte on the receiver's one-cycle done tick and holds it until the consumer (keyboard/display logic or a UART TX loopback) pops it. The buffer is first-word-fall-through. It reports occupancy and flags overrun when a byte arrives while the buffer is full.

---
 rtl/uart_rx_fifo.sv | 118 +++++++++++
 tb/tb_uart_rx_fifo.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver, with occupancy and sticky overrun.
// Optional almost-full flag enabled by defining UART_RX_FIFO_ALMOST_FULL_EN.
module uart_rx_fifo #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 4
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,parameter int unsigned AF_LEVEL = 12
`endif
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              wr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              rd,
   input  logic              clr_ovr,
   output logic [DATA_W-1:0] r_data,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overrun
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
  ,output logic              almost_full
`endif
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wr_ptr;
   logic [ADDR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              r_empty;
   logic              r_full;
   logic              r_overrun;

   logic              w_push;
   logic              w_pop;
   logic              w_drop;
   logic [CNT_W-1:0]  w_count_nxt;

   // A full buffer still accepts a write when a pop frees the slot in the same edge.
   always_comb begin
      w_push      = 1'b0;
      w_pop       = 1'b0;
      w_drop      = 1'b0;
      w_count_nxt = r_count;

      w_push = wr & (~r_full | rd);
      w_pop  = rd & ~r_empty;
      w_drop = wr & r_full & ~rd;

      case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CNT_W'(1);
         2'b01:   w_count_nxt = r_count - CNT_W'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   // Storage array carries no reset; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_empty  <= 1'b1;
         r_full   <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
         end
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
         r_full  <= (w_count_nxt == CNT_W'(DEPTH));
      end
   end

   // Sticky overrun: a drop in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_overrun <= 1'b0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
      end else if (clr_ovr) begin
         r_overrun <= 1'b0;
      end
   end

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   logic r_almost_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_count_nxt >= CNT_W'(AF_LEVEL));
      end
   end

   assign almost_full = r_almost_full;
`endif

   assign r_data  = r_mem[r_rd_ptr];
   assign empty   = r_empty;
   assign full    = r_full;
   assign count   = r_count;
   assign overrun = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomized scoreboard bench for uart_rx_fifo: a queue model tracks contents, a negedge monitor compares.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       wr = 1'b0;
   logic [7:0] w_data = 8'h00;
   logic       rd = 1'b0;
   logic       clr_ovr = 1'b0;
   logic [7:0] r_data;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
   logic       almost_full;
`endif

   int errs   = 0;
   int checks = 0;

   logic [7:0] exp_q[$];
   logic       m_ovr = 1'b0;

   uart_rx_fifo dut (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .w_data  (w_data),
      .rd      (rd),
      .clr_ovr (clr_ovr),
      .r_data  (r_data),
      .empty   (empty),
      .full    (full),
      .count   (count),
      .overrun (overrun)
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
     ,.almost_full (almost_full)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errs++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, expv, expv, $time);
      end
   endtask

   // Reference model: the buffer is a bounded queue of bytes.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_q.delete();
         m_ovr = 1'b0;
      end else begin
         int sz;
         sz = exp_q.size();
         if (rd && sz > 0) void'(exp_q.pop_front());
         if (wr && (sz < DEPTH || rd)) exp_q.push_back(w_data);
         if (wr && sz == DEPTH && !rd) m_ovr = 1'b1;
         else if (clr_ovr) m_ovr = 1'b0;
      end
   end

   // Monitor: whenever a byte is presented it must be the oldest one outstanding.
   always @(negedge clk) begin
      chk("count", int'(count), exp_q.size());
      chk("empty", int'(empty), int'(exp_q.size() == 0));
      chk("full", int'(full), int'(exp_q.size() == DEPTH));
      chk("overrun", int'(overrun), int'(m_ovr));
      if (exp_q.size() > 0) chk("r_data", int'(r_data), int'(exp_q[0]));
`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      chk("almost_full", int'(almost_full), int'(exp_q.size() >= 12));
`endif
   end

   task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
      wr      = w;
      w_data  = d;
      rd      = r;
      clr_ovr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && exp_q.size() > 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("drained", exp_q.size(), 0);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("reset_count", int'(count), 0);
      chk("reset_empty", int'(empty), 1);
      reset = 1'b1;

      repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);
      repeat (3) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rd_empty_count", int'(count), 0);

      step(1'b1, 8'h1C, 1'b0, 1'b0);
      chk("one_rdata", int'(r_data), 8'h1C);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("one_popped_empty", int'(empty), 1);

      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_count", int'(count), 16);
      chk("fill_full", int'(full), 1);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      chk("drop_overrun", int'(overrun), 1);
      chk("drop_count", int'(count), 16);
      for (int i = 0; i < 16; i++) begin
         chk("inorder", int'(r_data), i);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_alone", int'(overrun), 0);

      for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("full_wr_rd_count", int'(count), 16);
      chk("full_wr_rd_ovr", int'(overrun), 0);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("clr_vs_drop", int'(overrun), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("clr_after", int'(overrun), 0);
      for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("last_is_55", int'(r_data), 8'h55);
      drain();

      // Wrap-around with a shallow occupancy of one to three.
      begin
         int nwr = 0;
         for (int k = 0; k < 400 && nwr < 40; k++) begin
            logic w, r;
            int sz;
            sz = exp_q.size();
            w  = (sz <= 1) ? 1'b1 : 1'($urandom_range(0, 1));
            r  = (sz == 0) ? 1'b0 : (sz >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            if (w) nwr++;
            step(w, 8'($urandom), r, 1'b0);
         end
         chk("wrap_writes", nwr, 40);
      end
      drain();

      // Random traffic biased first toward filling, then toward draining.
      for (int k = 0; k < 300; k++)
         step(1'($urandom_range(0, 9) < 8), 8'($urandom), 1'($urandom_range(0, 9) < 3),
              1'($urandom_range(0, 9) == 0));
      for (int k = 0; k < 200; k++)
         step(1'($urandom_range(0, 9) < 3), 8'($urandom), 1'($urandom_range(0, 9) < 7),
              1'($urandom_range(0, 9) < 2));
      drain();

`ifdef UART_RX_FIFO_ALMOST_FULL_EN
      for (int i = 0; i < 12; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("af_at_12", int'(almost_full), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("af_at_11", int'(almost_full), 0);
      drain();
`endif

      for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("pre_reset_count", int'(count), 7);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      chk("async_count", int'(count), 0);
      chk("async_empty", int'(empty), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      #2 reset = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 8'h3E, 1'b0, 1'b0);
      chk("post_reset_rdata", int'(r_data), 8'h3E);
      chk("post_reset_count", int'(count), 1);
      step(1'b0, 8'h00, 1'b0, 1'b0);
      drain();
      repeat (2) step(1'b0, 8'h00, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
